// File: rtl/spi_column_loader.sv
// spi_column_loader: frames the SPI byte stream (SOF, then NUM_COLS 16-bit
// words, low byte first) into the back bank of a double-buffered column
// buffer. The banks swap only on a renderer vsync once a full frame is in.
module spi_column_loader #(
    parameter int          NUM_COLS = 640,
    parameter int          ADDR_W   = 10,
    parameter logic [7:0]  SOF      = 8'hA5,
    parameter int          TIMEOUT  = 65535
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cs,
    input  logic [7:0]        rx_byte,
    input  logic              rx_valid,
    input  logic              vsync,
    output logic              wr_en,
    output logic              wr_bank,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [15:0]       wr_data,
    output logic              front_bank,
    output logic              frame_done,
    output logic              frame_err,
    output logic              overrun,
    output logic              busy
);

    localparam int TW = $clog2(TIMEOUT + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LO   = 2'd1;
    localparam logic [1:0] S_HI   = 2'd2;
    localparam logic [1:0] S_WAIT = 2'd3;

    localparam logic [ADDR_W-1:0] LAST_COL = ADDR_W'(NUM_COLS - 1);
    localparam logic [TW-1:0]     TMO_MAX  = TW'(TIMEOUT);

    logic [1:0]        cs_q;
    logic [2:0]        rv_q;
    logic              strb_q;

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] col_q, col_d;
    logic [7:0]        lo_q, lo_d;
    logic [TW-1:0]     tmr_q, tmr_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [15:0]       wr_data_q, wr_data_d;
    logic              front_q, front_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              ovr_q, ovr_d;

    // Synchronize cs/rx_valid and register the byte strobe (rising edge of
    // synced rx_valid qualified by synced cs low). cs resets to inactive.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cs_q   <= 2'b11;
            rv_q   <= 3'b000;
            strb_q <= 1'b0;
        end else begin
            cs_q   <= {cs_q[0], cs};
            rv_q   <= {rv_q[1:0], rx_valid};
            strb_q <= rv_q[1] & ~rv_q[2] & ~cs_q[1];
        end
    end

    // Framing FSM next-state: SOF hunt, low/high byte pairing, inter-byte
    // timeout, and the wait for a frame boundary before swapping banks.
    always_comb begin
        state_d   = state_q;
        col_d     = col_q;
        lo_d      = lo_q;
        tmr_d     = tmr_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        front_d   = front_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        ovr_d     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (strb_q && rx_byte == SOF) begin
                    state_d = S_LO;
                    col_d   = '0;
                    tmr_d   = '0;
                end
            end
            S_LO: begin
                if (strb_q) begin
                    lo_d    = rx_byte;
                    tmr_d   = '0;
                    state_d = S_HI;
                end else if (tmr_q == TMO_MAX) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            S_HI: begin
                if (strb_q) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = col_q;
                    wr_data_d = {rx_byte, lo_q};
                    tmr_d     = '0;
                    if (col_q == LAST_COL) begin
                        state_d = S_WAIT;
                    end else begin
                        col_d   = col_q + 1'b1;
                        state_d = S_LO;
                    end
                end else if (tmr_q == TMO_MAX) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            default: begin
                // The last write is still on the bus in the first WAIT cycle;
                // a vsync there belongs to the frame being rendered, not ours.
                if (vsync && !wr_en_q) begin
                    front_d = ~front_q;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
                if (strb_q) begin
                    ovr_d = 1'b1;
                end
            end
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            col_q     <= '0;
            lo_q      <= '0;
            tmr_q     <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            front_q   <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            col_q     <= col_d;
            lo_q      <= lo_d;
            tmr_q     <= tmr_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            front_q   <= front_d;
            done_q    <= done_d;
            err_q     <= err_d;
            ovr_q     <= ovr_d;
        end
    end

    assign wr_en      = wr_en_q;
    assign wr_bank    = ~front_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign front_bank = front_q;
    assign frame_done = done_q;
    assign frame_err  = err_q;
    assign overrun    = ovr_q;
    assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_spi_column_loader.sv
// Bench for spi_column_loader: byte-level SPI master model, write monitor,
// and expected frames computed directly from the words sent.
module tb_spi_column_loader;

    localparam int NC  = 640;
    localparam int AW  = 10;
    localparam int TMO = 2000;
    localparam logic [7:0] SOFB = 8'hA5;

    logic          clk, rst_n, cs, rx_valid, vsync;
    logic [7:0]    rx_byte;
    logic          wr_en, wr_bank, front_bank, frame_done, frame_err, overrun, busy;
    logic [AW-1:0] wr_addr;
    logic [15:0]   wr_data;

    spi_column_loader #(.NUM_COLS(NC), .ADDR_W(AW), .SOF(SOFB), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .cs(cs), .rx_byte(rx_byte), .rx_valid(rx_valid),
        .vsync(vsync), .wr_en(wr_en), .wr_bank(wr_bank), .wr_addr(wr_addr),
        .wr_data(wr_data), .front_bank(front_bank), .frame_done(frame_done),
        .frame_err(frame_err), .overrun(overrun), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          bank;
        logic [AW-1:0] addr;
        logic [15:0]   data;
    } wr_t;

    wr_t         wq[$];
    int          nd, ne, no;
    bit          busy_seen, coinc_hit;
    int          errors, checks;
    logic [15:0] fw[NC];

    // Monitor: record writes and count pulses, sampled on the falling edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (wr_en) wq.push_back('{bank: wr_bank, addr: wr_addr, data: wr_data});
            if (frame_done) nd++;
            if (frame_err) ne++;
            if (overrun) no++;
            if (busy) busy_seen = 1'b1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One byte per cs assertion; optionally fire vsync in the cycle the
    // resulting write is on the bus.
    task automatic send_byte(input logic [7:0] b, input bit coinc);
        rx_byte = b; cs = 1'b0; rx_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (coinc && wr_en && !coinc_hit) begin
                vsync = 1'b1; coinc_hit = 1'b1;
            end else begin
                vsync = 1'b0;
            end
        end
        cs = 1'b1; rx_valid = 1'b0; vsync = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic send_words(input int n, input bit coinc_last);
        send_byte(SOFB, 1'b0);
        for (int i = 0; i < n; i++) begin
            send_byte(fw[i][7:0], 1'b0);
            send_byte(fw[i][15:8], coinc_last && (i == n - 1));
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic pulse_vsync();
        vsync = 1'b1;
        @(negedge clk);
        vsync = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic chk_writes(input string tag, input int n, input logic bank);
        chk({tag, "_count"}, wq.size(), n);
        for (int i = 0; i < n && i < wq.size(); i++) begin
            chk({tag, "_addr"}, wq[i].addr, i);
            chk({tag, "_data"}, wq[i].data, fw[i]);
            chk({tag, "_bank"}, wq[i].bank, bank);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_wr_en"},   wr_en, 0);
        chk({tag, "_wr_bank"}, wr_bank, 1);
        chk({tag, "_wr_addr"}, wr_addr, 0);
        chk({tag, "_wr_data"}, wr_data, 0);
        chk({tag, "_front"},   front_bank, 0);
        chk({tag, "_done"},    frame_done, 0);
        chk({tag, "_err"},     frame_err, 0);
        chk({tag, "_ovr"},     overrun, 0);
        chk({tag, "_busy"},    busy, 0);
    endtask

    initial begin
        int cyc, nd0, ne0, no0;
        logic [7:0] b1, b2, b3;
        errors = 0; checks = 0; nd = 0; ne = 0; no = 0;
        busy_seen = 0; coinc_hit = 0;
        rst_n = 1'b0; cs = 1'b1; rx_valid = 1'b0; vsync = 1'b0; rx_byte = 8'h00;
        repeat (3) @(negedge clk);
        chk_reset("rst");
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // vsync while idle and junk bytes before SOF are ignored
        pulse_vsync();
        chk("idle_vsync_front", front_bank, 0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h55, 1'b0);
        repeat (4) @(negedge clk);
        chk("prefix_writes", wq.size(), 0);
        chk("prefix_busy", busy_seen, 0);

        // Frame 1: col n = 16'h1000 + n into bank 1
        for (int i = 0; i < NC; i++) fw[i] = 16'h1000 + 16'(i);
        send_words(NC, 1'b0);
        chk_writes("f1", NC, 1'b1);
        chk("f1_busy_wait", busy, 1);
        chk("f1_front_pre", front_bank, 0);
        chk("f1_done_pre", nd, 0);
        pulse_vsync();
        chk("f1_done", nd, 1);
        chk("f1_front", front_bank, 1);
        chk("f1_wr_bank", wr_bank, 0);
        chk("f1_busy_idle", busy, 0);

        // Timeout: SOF + 3 bytes, then silence
        wq.delete(); ne0 = ne; nd0 = nd;
        b1 = 8'($urandom); b2 = 8'($urandom); b3 = 8'($urandom);
        send_byte(SOFB, 1'b0);
        send_byte(b1, 1'b0);
        send_byte(b2, 1'b0);
        send_byte(b3, 1'b0);
        cyc = 0;
        while (ne == ne0 && cyc < TMO + 100) begin
            @(negedge clk);
            cyc++;
        end
        chk("tmo_err", ne, ne0 + 1);
        chk("tmo_window", (cyc >= TMO - 8 && cyc <= TMO + 8), 1);
        repeat (3) @(negedge clk);
        chk("tmo_err_once", ne, ne0 + 1);
        chk("tmo_writes", wq.size(), 1);
        if (wq.size() > 0) begin
            chk("tmo_addr", wq[0].addr, 0);
            chk("tmo_data", wq[0].data, {b2, b1});
            chk("tmo_bank", wq[0].bank, 0);
        end
        chk("tmo_busy", busy, 0);
        chk("tmo_front", front_bank, 1);
        chk("tmo_no_swap", nd, nd0);

        // Reset after 100 columns
        wq.delete();
        for (int i = 0; i < NC; i++) fw[i] = 16'($urandom);
        send_words(100, 1'b0);
        chk("mid_writes", wq.size(), 100);
        chk("mid_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        chk_reset("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Frame 2 (random data) after reset: bank 1, vsync on last write ignored
        wq.delete(); nd0 = nd;
        for (int i = 0; i < NC; i++) fw[i] = 16'($urandom);
        send_words(NC, 1'b1);
        chk("f2_coinc_hit", coinc_hit, 1);
        chk_writes("f2", NC, 1'b1);
        chk("f2_coinc_no_swap", nd, nd0);
        chk("f2_front_pre", front_bank, 0);
        chk("f2_busy_wait", busy, 1);

        // Overrun: two bytes (one an SOF) while waiting for swap
        no0 = no;
        send_byte(SOFB, 1'b0);
        send_byte(8'($urandom), 1'b0);
        repeat (3) @(negedge clk);
        chk("ovr_count", no, no0 + 2);
        chk("ovr_no_write", wq.size(), NC);
        chk("ovr_busy", busy, 1);
        pulse_vsync();
        chk("f2_done", nd, nd0 + 1);
        chk("f2_front", front_bank, 1);
        chk("f2_wr_bank", wr_bank, 0);
        chk("f2_busy_idle", busy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/spi_column_loader.md
# spi_column_loader

Sequences the byte stream from the SPI receiver into the double-buffered column buffer the raycaster renderer reads. Crosses the SPI byte-valid flag into the system clock domain, frames the stream (start byte, then 640 16-bit column words), writes the back bank, and swaps banks only at a renderer frame boundary.

## Interface
- NUM_COLS, 640, column words per frame
- ADDR_W, 10, column address width
- SOF, 8'hA5, start-of-frame byte
- TIMEOUT, 65535, max clk cycles between bytes inside a frame
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- cs  in  1  raw SPI chip select (active low, asynchronous to clk)
- rx_byte  in  8  byte from SPI receiver
- rx_valid  in  1  receiver byte-complete flag (SCK domain, level; high until cs rises)
- vsync  in  1  renderer frame-boundary pulse, one clk wide
- wr_en  out  1  column buffer write strobe
- wr_bank  out  1  bank written (always ~front_bank)
- wr_addr  out  ADDR_W  column index
- wr_data  out  16  column word
- front_bank  out  1  bank the renderer reads
- frame_done  out  1  one-cycle pulse on bank swap
- frame_err  out  1  one-cycle pulse on timeout abort
- overrun  out  1  one-cycle pulse on byte dropped in WAIT_SWAP
- busy  out  1  high in LO, HI, WAIT_SWAP

## Operation
- cs and rx_valid each pass through a 2-FF synchronizer; byte strobe = rising edge of synced rx_valid while synced cs low. rx_byte sampled on the strobe cycle (stable: receiver holds it while rx_valid high and cs low).
- One byte per cs assertion; master holds cs low >= 4 clk after the 8th SCK edge.
- States: IDLE, LO, HI, WAIT_SWAP.
- IDLE: strobe with byte == SOF -> LO, col counter = 0; other bytes discarded silently.
- LO: strobe -> latch low byte, -> HI.
- HI: strobe -> wr_data = {byte, low}, wr_addr = col, wr_en pulses; if col == NUM_COLS-1 -> WAIT_SWAP, else col+1, -> LO.
- Inter-byte counter resets on every strobe and on entering LO; in LO/HI reaching TIMEOUT -> frame_err pulse, -> IDLE, no swap; bank contents already written are left as-is.
- WAIT_SWAP: vsync -> front_bank toggles, frame_done pulses, -> IDLE. Strobe -> byte dropped, overrun pulses (an SOF here is also dropped).
- vsync outside WAIT_SWAP: ignored.
- Column count arithmetic is ADDR_W bits; no wrap beyond NUM_COLS-1 possible.

## Timing
- Reset values: wr_en 0, wr_bank 1, wr_addr 0, wr_data 0, front_bank 0, frame_done 0, frame_err 0, overrun 0, busy 0, state IDLE, col 0.
- Strobe is asserted 3 clk after rx_valid rises (2 sync + edge detect).
- wr_en/wr_addr/wr_data registered: valid the cycle after the HI-byte strobe; wr_en high exactly 1 cycle.
- State moves to WAIT_SWAP in the same edge as the last write; vsync in that very cycle (write still on the bus) is ignored; first vsync sampled in WAIT_SWAP swaps.
- front_bank and wr_bank change on the same edge frame_done rises.
- Strobe and TIMEOUT in the same cycle: strobe wins.
- rst_n low mid-frame: all state to reset values immediately; front_bank returns to 0.

## Test plan
- Send SOF then 1280 bytes (col n = 16'h1000+n, low first), then vsync -> 640 writes addr 0..639 data 16'h1000..16'h127F to bank 1, frame_done pulse, front_bank = 1, next frame writes bank 0.
- Bytes 8'h00, 8'h55 before SOF -> no writes, busy stays 0; SOF then data proceeds normally.
- SOF, 3 bytes, then idle TIMEOUT+1 cycles -> one write (addr 0), frame_err pulse, state IDLE, front_bank unchanged.
- Full frame, then 2 bytes before vsync -> overrun pulses twice, no writes; vsync -> swap.
- vsync coincident with last write cycle -> no swap; second vsync -> frame_done.
- rst_n low after 100 columns -> all outputs reset values; new SOF frame writes from addr 0 into bank 1.
